// File: rtl/deser_pkg.sv
// Shared definitions for the chunked word link (deserializer and serializer side).
// Chunk count and counter width helpers so both ends agree on the framing.
package deser_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ACC,
        HOLD,
        STALL
    } deser_state_e;

    function automatic int n_chunk(input int in_w, input int out_w);
        return out_w / in_w;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IN_W  = 8;
    localparam int DEF_OUT_W = 24;
    localparam int CNT_W     = cnt_w(n_chunk(DEF_IN_W, DEF_OUT_W));

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry word register with load/pop and a valid flag.
// A load on the same edge as a pop wins, so a swap keeps valid set.
module word_hold_reg #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         rd,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (rd) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/deserializer.sv
// Receive end of the chunked word link: MSB-first chunks into full words,
// double-buffered between the shift register and the output holding register.
module deserializer
    import deser_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             data_in_val,
    input  logic [IN_W-1:0]  data_in,
    input  logic             sof,
    output logic             in_rdy,
    output logic             data_out_val,
    output logic [OUT_W-1:0] data_out,
    input  logic             rd,
    output logic             ovf,
    output logic             sync_err,
    input  logic             clr_err
);

    localparam int N   = n_chunk(IN_W, OUT_W);
    localparam int CW  = cnt_w(N);
    localparam int SHW = (N > 1) ? (N - 1) * IN_W : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (IN_W < 1 || N < 1 || (OUT_W % IN_W) != 0) begin : g_bad_cfg
        $error("deserializer: OUT_W must be a positive multiple of IN_W");
    end

    logic [CW-1:0]    cnt;
    logic [OUT_W-1:0] word;
    logic             accept;
    logic             done;
    deser_state_e     st;

    always_comb begin
        st = EMPTY;
        unique case (1'b1)
            data_out_val && cnt == CNT_LAST:  st = STALL;
            data_out_val && cnt != CNT_LAST:  st = HOLD;
            !data_out_val && cnt != '0:       st = ACC;
            default:                          st = EMPTY;
        endcase
    end

    // A pop in STALL frees the holding register on the same edge.
    assign in_rdy = (st != STALL) | rd;
    assign accept = data_in_val & in_rdy;

    if (N > 1) begin : g_shift
        logic [SHW-1:0] shift;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                shift <= '0;
            end else if (accept) begin
                if (sof) shift <= SHW'(data_in);
                else     shift <= SHW'({shift, data_in});
            end
        end

        assign word = {shift, data_in};
        assign done = accept & ~sof & (cnt == CNT_LAST);
    end else begin : g_single
        assign word = data_in;
        assign done = accept;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (accept) begin
            if (done)     cnt <= '0;
            else if (sof) cnt <= CW'(1);
            else          cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf      <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            ovf      <= (data_in_val & ~in_rdy) | (ovf & ~clr_err);
            sync_err <= (accept & sof & (cnt != '0)) | (sync_err & ~clr_err);
        end
    end

    word_hold_reg #(
        .W(OUT_W)
    ) u_hold (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (done),
        .d      (word),
        .rd     (rd),
        .valid  (data_out_val),
        .q      (data_out)
    );

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer (IN_W=8, OUT_W=24): vector table, hand sequences,
// and a word scoreboard checked whenever the consumer pops.
module tb_deserializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        data_in_val;
    logic [7:0]  data_in;
    logic        sof;
    logic        in_rdy;
    logic        data_out_val;
    logic [23:0] data_out;
    logic        rd;
    logic        ovf;
    logic        sync_err;
    logic        clr_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] sb_q[$];

    typedef struct {
        logic        val;
        logic [7:0]  din;
        logic        sof;
        logic        rd;
        logic        clr;
        logic        push;
        logic [23:0] pw;
        logic        e_rdy;
        logic        e_val;
        logic [23:0] e_dout;
        logic        e_ovf;
        logic        e_sync;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    deserializer #(
        .IN_W (8),
        .OUT_W(24)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_in_val (data_in_val),
        .data_in     (data_in),
        .sof         (sof),
        .in_rdy      (in_rdy),
        .data_out_val(data_out_val),
        .data_out    (data_out),
        .rd          (rd),
        .ovf         (ovf),
        .sync_err    (sync_err),
        .clr_err     (clr_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every popped word must match the oldest expected word.
    always @(negedge clk) begin
        if (reset_n && rd && data_out_val) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_pop: got %h expected none (queue empty)", data_out);
            end else begin
                logic [23:0] e;
                e = sb_q.pop_front();
                if (data_out !== e) begin
                    n_err++;
                    $display("FAIL sb_word: got %h expected %h", data_out, e);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic s,
                         input logic r, input logic c);
        @(posedge clk);
        #1;
        data_in_val = v;
        data_in     = d;
        sof         = s;
        rd          = r;
        clr_err     = c;
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic s,
                       input logic r, input logic c, input logic p,
                       input logic [23:0] pw, input logic er, input logic ev,
                       input logic [23:0] ed, input logic eo, input logic es);
        vec_t t;
        t = '{v, d, s, r, c, p, pw, er, ev, ed, eo, es};
        vecs.push_back(t);
    endtask

    task automatic chk_all(input string tag, input logic er, input logic ev,
                           input logic [23:0] ed, input logic eo, input logic es);
        chk({tag, ".in_rdy"}, 32'(in_rdy), 32'(er));
        chk({tag, ".val"}, 32'(data_out_val), 32'(ev));
        chk({tag, ".dout"}, 32'(data_out), 32'(ed));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
        chk({tag, ".sync"}, 32'(sync_err), 32'(es));
    endtask

    initial begin
        logic [23:0] words[$];
        int          wi;
        int          ci;
        int          guard;

        reset_n     = 1'b0;
        data_in_val = 1'b0;
        data_in     = '0;
        sof         = 1'b0;
        rd          = 1'b0;
        clr_err     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk_all("reset0", 1'b1, 1'b0, 24'h0, 1'b0, 1'b0);

        // Full word held plus one partial chunk, then reset mid-word.
        drive(1, 8'hA1, 1, 0, 0);
        drive(1, 8'hB2, 0, 0, 0);
        drive(1, 8'hC3, 0, 0, 0);
        drive(1, 8'hD4, 0, 0, 0);
        drive(0, 8'h00, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst.val", 32'(data_out_val), 32'(1));
        chk("pre_rst.dout", 32'(data_out), 32'h00A1B2C3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst.val", 32'(data_out_val), 32'(0));
        chk("async_rst.dout", 32'(data_out), 32'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk_all("reset1", 1'b1, 1'b0, 24'h0, 1'b0, 1'b0);

        // val din sof rd clr push pw | rdy val dout ovf sync
        add(1, 8'hAB, 0, 0, 0, 0, 24'h0,      1, 0, 24'h000000, 0, 0);
        add(1, 8'hCD, 0, 0, 0, 0, 24'h0,      1, 0, 24'h000000, 0, 0);
        add(1, 8'hEF, 0, 0, 0, 1, 24'hABCDEF, 1, 0, 24'h000000, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 24'h0,      1, 1, 24'hABCDEF, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 24'h0,      1, 0, 24'hABCDEF, 0, 0);
        add(1, 8'h11, 0, 0, 0, 0, 24'h0,      1, 0, 24'hABCDEF, 0, 0);
        add(1, 8'h22, 0, 0, 0, 0, 24'h0,      1, 0, 24'hABCDEF, 0, 0);
        add(1, 8'h33, 0, 0, 0, 1, 24'h112233, 1, 0, 24'hABCDEF, 0, 0);
        add(1, 8'h44, 0, 0, 0, 0, 24'h0,      1, 1, 24'h112233, 0, 0);
        add(1, 8'h55, 0, 0, 0, 0, 24'h0,      1, 1, 24'h112233, 0, 0);
        add(1, 8'h66, 0, 0, 0, 0, 24'h0,      0, 1, 24'h112233, 0, 0);
        add(1, 8'h77, 0, 1, 0, 1, 24'h445577, 1, 1, 24'h112233, 1, 0);
        add(0, 8'h00, 0, 0, 0, 0, 24'h0,      1, 1, 24'h445577, 1, 0);
        add(0, 8'h00, 0, 1, 1, 0, 24'h0,      1, 1, 24'h445577, 1, 0);
        add(0, 8'h00, 0, 0, 0, 0, 24'h0,      1, 0, 24'h445577, 0, 0);
        add(1, 8'h11, 0, 0, 0, 0, 24'h0,      1, 0, 24'h445577, 0, 0);
        add(1, 8'h22, 0, 0, 0, 0, 24'h0,      1, 0, 24'h445577, 0, 0);
        add(1, 8'h33, 1, 0, 0, 0, 24'h0,      1, 0, 24'h445577, 0, 0);
        add(1, 8'h44, 0, 0, 0, 0, 24'h0,      1, 0, 24'h445577, 0, 1);
        add(1, 8'h55, 0, 0, 0, 1, 24'h334455, 1, 0, 24'h445577, 0, 1);
        add(0, 8'h00, 0, 1, 0, 0, 24'h0,      1, 1, 24'h334455, 0, 1);
        add(0, 8'h00, 0, 0, 1, 0, 24'h0,      1, 0, 24'h334455, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 24'h0,      1, 0, 24'h334455, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].val, vecs[i].din, vecs[i].sof, vecs[i].rd, vecs[i].clr);
            if (vecs[i].push) sb_q.push_back(vecs[i].pw);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_val,
                    vecs[i].e_dout, vecs[i].e_ovf, vecs[i].e_sync);
        end

        // Streaming with rd tied high: in_rdy must never drop.
        for (int i = 1; i <= 6; i++) begin
            logic [7:0] b;
            b = 8'(i * 8'h11);
            drive(1, b, 0, 1, 0);
            if (i == 3) sb_q.push_back(24'h112233);
            if (i == 6) sb_q.push_back(24'h445566);
            @(negedge clk);
            chk($sformatf("stream%0d.in_rdy", i), 32'(in_rdy), 32'(1));
        end
        drive(0, 8'h00, 0, 1, 0);
        drive(0, 8'h00, 0, 1, 0);
        @(negedge clk);
        chk("stream.drained", 32'(data_out_val), 32'(0));
        chk("stream.ovf", 32'(ovf), 32'(0));

        // Loopback through a serializer model with random consumer pops.
        words = '{24'hABCDEF, 24'h123456};
        for (int i = 0; i < 6; i++) words.push_back(24'($urandom));
        foreach (words[i]) sb_q.push_back(words[i]);
        wi = 0;
        ci = 0;
        guard = 0;
        while (wi < words.size() && guard < 2000) begin
            @(posedge clk);
            #1;
            rd          = 1'($urandom_range(0, 1));
            clr_err     = 1'b0;
            data_in_val = 1'b0;
            #1;
            if (in_rdy) begin
                data_in_val = 1'b1;
                data_in     = words[wi][23 - 8*ci -: 8];
                sof         = (ci == 0);
                if (ci == 2) begin
                    ci = 0;
                    wi++;
                end else begin
                    ci++;
                end
            end
            guard++;
        end
        chk("loop.bound", 32'(guard < 2000), 32'(1));
        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            drive(0, 8'h00, 0, 1, 0);
            guard++;
        end
        drive(0, 8'h00, 0, 0, 0);
        @(negedge clk);
        chk("loop.drained", 32'(sb_q.size()), 32'(0));
        chk("loop.ovf", 32'(ovf), 32'(0));
        chk("loop.sync", 32'(sync_err), 32'(0));
        chk("loop.val", 32'(data_out_val), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
